// File: rtl/ext_bus_register_file.sv
// Bus-mapped register file with byte-lane writes and read-only registers.
// Acknowledge arrives 1+WAIT_STATES cycles after bus_enable rises; the master holds bus_enable until it sees it.
module ext_bus_register_file #(
  parameter int                  NUM_REGS    = 4,
  parameter int                  DATA_W      = 16,
  parameter int                  ADDR_W      = 19,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         bus_enable,
  input  logic [DATA_W/8-1:0]          byte_enable,
  input  logic                         rw,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         acknowledge,
  output logic [DATA_W-1:0]            read_data,
  output logic [NUM_REGS*DATA_W-1:0]   registers,
  output logic [NUM_REGS-1:0]          write_strobe,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_value
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int LANES = DATA_W / 8;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rw_q, rw_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REGS-1:0] strobe_q, strobe_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_val;

  assign req_idx = address[ADDR_W-1 -: IDX_W];

  generate
    if (ADDR_W > IDX_W) begin : g_addr_low
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[ADDR_W-IDX_W-1:0];
    end
  endgenerate

  // With zero wait states ACK is entered on the capture edge, so the read
  // must be steered by the live address rather than the captured one.
  always_comb begin
    rd_idx = (state_q == IDLE) ? req_idx : idx_q;
    rd_val = RO_MASK[rd_idx] ? ro_value[int'(rd_idx)*DATA_W +: DATA_W] : regs_q[rd_idx];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    strobe_d = '0;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        if (bus_enable) begin
          idx_d   = req_idx;
          rw_d    = rw;
          be_d    = byte_enable;
          wdata_d = write_data;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (rw) rdata_d = rd_val;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus_enable) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (rw_q) rdata_d = rd_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = HOLD;
        if (!rw_q && !RO_MASK[idx_q] && (|be_q)) begin
          for (int k = 0; k < LANES; k++) begin
            if (be_q[k]) regs_d[idx_q][8*k +: 8] = wdata_q[8*k +: 8];
          end
          strobe_d[idx_q] = 1'b1;
        end
      end
      HOLD: begin
        if (!bus_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      rw_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      regs_q   <= regs_d;
    end
  end

  assign acknowledge  = ack_q;
  assign read_data    = rdata_q;
  assign write_strobe = strobe_q;

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign registers[g*DATA_W +: DATA_W] = regs_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_ext_bus_register_file.sv
// Directed bench: dut_a has two wait states and register 3 read-only, dut_b has no wait states.
module tb_ext_bus_register_file;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [18:0] address;
  logic        en_a, en_b;
  logic [1:0]  byte_enable;
  logic        rw;
  logic [15:0] write_data;
  logic [63:0] ro_value;

  logic        ack_a, ack_b;
  logic [15:0] rd_a, rd_b;
  logic [63:0] regs_a, regs_b;
  logic [3:0]  strb_a, strb_b;

  int tests = 0;
  int fails = 0;
  bit use_b = 1'b0;

  always #5 clk = ~clk;

  ext_bus_register_file #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(19), .WAIT_STATES(2), .RO_MASK(4'b1000)) dut_a (
    .clk_clk(clk), .reset_reset(reset_reset), .address(address), .bus_enable(en_a),
    .byte_enable(byte_enable), .rw(rw), .write_data(write_data), .acknowledge(ack_a),
    .read_data(rd_a), .registers(regs_a), .write_strobe(strb_a), .ro_value(ro_value));

  ext_bus_register_file #(.NUM_REGS(4), .DATA_W(16), .ADDR_W(19), .WAIT_STATES(0), .RO_MASK(4'b0000)) dut_b (
    .clk_clk(clk), .reset_reset(reset_reset), .address(address), .bus_enable(en_b),
    .byte_enable(byte_enable), .rw(rw), .write_data(write_data), .acknowledge(ack_b),
    .read_data(rd_b), .registers(regs_b), .write_strobe(strb_b), .ro_value(ro_value));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic v);
    if (use_b) en_b = v;
    else       en_a = v;
  endtask

  // One master transaction: wait (bounded) for acknowledge, optionally keep
  // bus_enable high afterwards, then release and let the FSM return to IDLE.
  task automatic xfer(input logic [18:0] addr, input logic rw_i, input logic [1:0] be_i,
                      input logic [15:0] wd, input int hold_extra, input bit scramble,
                      output int ack_cyc, output int n_ack, output logic [3:0] strb_or,
                      output int n_strb, output logic [15:0] rd_at_ack);
    logic       a;
    logic [3:0] s;
    address = addr; rw = rw_i; byte_enable = be_i; write_data = wd;
    set_en(1'b1);
    ack_cyc = -1; n_ack = 0; strb_or = '0; n_strb = 0; rd_at_ack = '0;
    for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
      tick();
      if (c == 1 && scramble) begin
        address    = addr ^ 19'h20000;
        write_data = ~wd;
      end
      a = use_b ? ack_b : ack_a;
      s = use_b ? strb_b : strb_a;
      if (a) begin
        ack_cyc = c; n_ack++;
        rd_at_ack = use_b ? rd_b : rd_a;
      end
      if (s != 0) begin strb_or |= s; n_strb++; end
    end
    for (int h = 0; h < hold_extra + 3; h++) begin
      if (h == hold_extra) set_en(1'b0);
      tick();
      a = use_b ? ack_b : ack_a;
      s = use_b ? strb_b : strb_a;
      if (a) n_ack++;
      if (s != 0) begin strb_or |= s; n_strb++; end
    end
  endtask

  int          ack_cyc, n_ack, n_strb;
  logic [3:0]  strb_or;
  logic [15:0] rdv;

  initial begin
    reset_reset = 1'b1; en_a = 1'b0; en_b = 1'b0; address = '0; rw = 1'b0;
    byte_enable = '0; write_data = '0;
    ro_value = {16'hBEEF, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) tick();
    check("rst_ack", {63'd0, ack_a}, 64'd0);
    check("rst_rd", {48'd0, rd_a}, 64'd0);
    check("rst_regs", regs_a, 64'd0);
    check("rst_strb", {60'd0, strb_a}, 64'd0);
    reset_reset = 1'b0;

    xfer(19'h20000, 1'b0, 2'b11, 16'hA5C3, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("w1_latency", ack_cyc, 64'd3);
    check("w1_strobe", {60'd0, strb_or}, 64'h2);
    check("w1_reg1", {48'd0, regs_a[31:16]}, 64'hA5C3);

    xfer(19'h40000, 1'b0, 2'b10, 16'h1234, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("w2_reg2_hi", {48'd0, regs_a[47:32]}, 64'h1200);
    check("w2_strobe", {60'd0, strb_or}, 64'h4);
    xfer(19'h40000, 1'b0, 2'b01, 16'h00FF, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("w3_reg2_lo", {48'd0, regs_a[47:32]}, 64'h12FF);

    xfer(19'h60000, 1'b0, 2'b11, 16'hFFFF, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("ro_w_ack", ack_cyc, 64'd3);
    check("ro_w_reg3", {48'd0, regs_a[63:48]}, 64'h0);
    check("ro_w_strobe", {60'd0, strb_or}, 64'h0);

    xfer(19'h60000, 1'b1, 2'b11, 16'h0000, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("ro_r_data", {48'd0, rdv}, 64'hBEEF);
    check("ro_r_held", {48'd0, rd_a}, 64'hBEEF);

    xfer(19'h20000, 1'b1, 2'b00, 16'h0000, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("r1_data", {48'd0, rdv}, 64'hA5C3);
    check("regs_flat", regs_a, 64'h0000_12FF_A5C3_0000);

    xfer(19'h00000, 1'b0, 2'b00, 16'hFFFF, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("be0_acks", n_ack, 64'd1);
    check("be0_strobe", {60'd0, strb_or}, 64'h0);
    check("be0_regs", regs_a, 64'h0000_12FF_A5C3_0000);

    // Abort: drop bus_enable during the first WAIT cycle.
    address = 19'h00000; rw = 1'b0; byte_enable = 2'b11; write_data = 16'h5555;
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_a) n_ack++;
    end
    check("abort_acks", n_ack, 64'd0);
    check("abort_regs", regs_a, 64'h0000_12FF_A5C3_0000);
    xfer(19'h40000, 1'b1, 2'b11, 16'h0000, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("abort_idle_lat", ack_cyc, 64'd3);
    check("abort_idle_rd", {48'd0, rdv}, 64'h12FF);

    xfer(19'h00000, 1'b0, 2'b11, 16'h1111, 0, 1'b1, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("scramble_regs", regs_a, 64'h0000_12FF_A5C3_1111);
    check("scramble_strobe", {60'd0, strb_or}, 64'h1);

    xfer(19'h00000, 1'b0, 2'b11, 16'hABCD, 5, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("hold_acks", n_ack, 64'd1);
    check("hold_strobes", n_strb, 64'd1);
    check("hold_reg0", {48'd0, regs_a[15:0]}, 64'hABCD);

    // Reset during the ACK cycle of a write.
    address = 19'h20000; rw = 1'b0; byte_enable = 2'b11; write_data = 16'h7777;
    en_a = 1'b1;
    ack_cyc = -1;
    for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
      tick();
      if (ack_a) ack_cyc = c;
    end
    check("rack_seen", ack_cyc, 64'd3);
    reset_reset = 1'b1;
    en_a = 1'b0;
    tick();
    check("rack_ack", {63'd0, ack_a}, 64'd0);
    check("rack_regs", regs_a, 64'd0);
    check("rack_strobe", {60'd0, strb_a}, 64'd0);

    // Request already pending while reset is high: accepted right after release.
    address = 19'h60000; rw = 1'b1; en_a = 1'b1;
    tick();
    reset_reset = 1'b0;
    xfer(19'h60000, 1'b1, 2'b11, 16'h0000, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("post_rst_lat", ack_cyc, 64'd3);
    check("post_rst_rd", {48'd0, rdv}, 64'hBEEF);

    use_b = 1'b1;
    xfer(19'h20000, 1'b0, 2'b11, 16'hCAFE, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("b_w_lat", ack_cyc, 64'd1);
    check("b_w_regs", regs_b, 64'h0000_0000_CAFE_0000);
    xfer(19'h20000, 1'b1, 2'b11, 16'h0000, 0, 1'b0, ack_cyc, n_ack, strb_or, n_strb, rdv);
    check("b_r_lat", ack_cyc, 64'd1);
    check("b_r_data", {48'd0, rdv}, 64'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_bus_register_file.md
EXT_BUS_REGISTER_FILE -- requirements
Module: ext_bus_register_file

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, meaning the register count; legal values are a power of 2 from 2 to 16.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the register and bus data width; legal values are multiples of 8 from 8 to 64.
REQ-003 The block SHALL have parameter ADDR_W, default 19, meaning the bus address width; it SHALL be at least log2(NUM_REGS).
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning the wait cycles inserted before acknowledge; legal range 0..15.
REQ-005 The block SHALL have parameter RO_MASK, default 0, NUM_REGS bits wide; bit i=1 makes register i read-only from the bus.
REQ-006 Port clk_clk SHALL be input, 1 bit: the single clock, all logic on its rising edge.
REQ-007 Port reset_reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-008 Port address SHALL be input, ADDR_W bits: register index = address[ADDR_W-1 -: log2(NUM_REGS)]; all other bits are ignored.
REQ-009 Port bus_enable SHALL be input, 1 bit: master request, held high until acknowledge is seen.
REQ-010 Port byte_enable SHALL be input, DATA_W/8 bits: per-byte-lane write enable.
REQ-011 Port rw SHALL be input, 1 bit: 1 = read, 0 = write.
REQ-012 Port write_data SHALL be input, DATA_W bits: write data.
REQ-013 Port acknowledge SHALL be output, 1 bit: one-cycle transfer-complete pulse.
REQ-014 Port read_data SHALL be output, DATA_W bits: registered read data.
REQ-015 Port registers SHALL be output, NUM_REGS*DATA_W bits: flat register contents, with register i at bits [i*DATA_W +: DATA_W].
REQ-016 Port write_strobe SHALL be output, NUM_REGS bits: a one-cycle pulse on bit i when register i is written.
REQ-017 Port ro_value SHALL be input, NUM_REGS*DATA_W bits: the value returned on reads of read-only registers.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, ACK and HOLD.
- IDLE: bus_enable=1 -> capture address, rw, byte_enable and write_data; go to ACK if WAIT_STATES=0, else load the wait counter with WAIT_STATES-1 and go to WAIT.
REQ-019 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to ACK when the counter is 0 and bus_enable=1.
REQ-020 If bus_enable falls in WAIT, the FSM SHALL abort to IDLE with no write, no acknowledge and no strobe.
REQ-021 acknowledge SHALL be high for exactly the single ACK cycle; ACK always goes to HOLD.
REQ-022 HOLD SHALL stay until bus_enable=0, then go to IDLE; a new request is accepted no earlier than the cycle after bus_enable is seen low.
REQ-023 Latency: bus_enable rise to acknowledge high SHALL be 1+WAIT_STATES clock cycles.
REQ-024 A write SHALL commit on the clock edge ending the ACK cycle, updating only the captured byte lanes: lane k takes captured write_data[8k+7:8k].
REQ-025 A write with byte_enable all-zero SHALL change no register but SHALL still acknowledge and SHALL NOT strobe.
REQ-026 A write to a register whose RO_MASK bit is set SHALL leave it unchanged and SHALL NOT strobe, but SHALL still acknowledge.
REQ-027 write_strobe[i] SHALL pulse in the cycle after ACK for every committed write to register i.
REQ-028 read_data SHALL be loaded on entry to ACK (valid during the acknowledge cycle) and held until the next read; byte_enable is ignored on reads.
REQ-029 The read value SHALL be ro_value slice i if RO_MASK[i]=1, else register i.
REQ-030 Address and data SHALL be taken from the IDLE capture; bus changes during WAIT, ACK or HOLD SHALL be ignored.

Reset
REQ-031 While reset_reset=1, on each clock edge: FSM -> IDLE, all registers -> 0, read_data -> 0, acknowledge -> 0, write_strobe -> 0, wait counter -> 0.
REQ-032 Reset mid-transfer SHALL discard the pending transfer; the first request accepted after reset SHALL be the cycle after reset_reset falls, provided bus_enable=1.

Verification (DATA_W=16, NUM_REGS=4, ADDR_W=19, WAIT_STATES=2, RO_MASK=4'b1000 unless noted)
REQ-033 Write address=19'h20000, data 16'hA5C3, byte_enable 2'b11 -> acknowledge on cycle 3, register 1=16'hA5C3, write_strobe=4'b0010 one cycle later.
REQ-034 Write register 2 data 16'h1234 with byte_enable 2'b10 over initial 0 -> register 2=16'h1200; then byte_enable 2'b01 data 16'h00FF -> register 2=16'h12FF.
REQ-035 Write register 3 (read-only) data 16'hFFFF, then read it with ro_value slice 3=16'hBEEF -> register 3 stays 0, no strobe, read_data=16'hBEEF during acknowledge.
REQ-036 Drop bus_enable in the first WAIT cycle of a write -> no acknowledge, registers unchanged, FSM back in IDLE.
REQ-037 Assert reset_reset during ACK of a write -> registers all 0, acknowledge low the next cycle; with WAIT_STATES=0, a read acknowledges in the cycle after request.
REQ-038 Hold bus_enable high for 5 cycles after acknowledge -> exactly one acknowledge and one write.
